// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] hilo_q;

  modport master (output start, op, rs, rt, input busy, done, div_by_zero, hilo_q);
  modport slave  (input start, op, rs, rt, output busy, done, div_by_zero, hilo_q);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; MULDIV_MULT_1CYC_EN selects a single-cycle multiplier.
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO complete here
// S_RUN  | 32 shift-add or restoring-divide iterations
// S_FIX  | sign correction, HI/LO write, done pulse
module muldiv_unit #(
  parameter int ITER_BITS = 5
) (
  input logic         clk_cpu,
  input logic         reset,
  muldiv_unit_if.slave bus
);
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t               state_q;
  logic [ITER_BITS-1:0] cnt_q;
  logic                 is_div_q, neg_lo_q, neg_hi_q, dz_q;
  logic [31:0]          a_q, rem_q, dvd_q;
  logic [63:0]          acc_q, hilo_q;
  logic                 busy_q, done_q, dz_out_q;

  logic        take, sgn;
  logic [31:0] rs_mag, rt_mag, quo_fix, rem_fix, rem_d;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [63:0] acc_d, prod_fix, result;
`ifdef MULDIV_MULT_1CYC_EN
  logic [63:0] prod_1c;
`endif

  always_comb begin
    // FIX edge can accept the next request so back-to-back ops have no bubble
    take   = bus.start && (state_q == S_IDLE || state_q == S_FIX);
    sgn    = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    rs_mag = (sgn && bus.rs[31]) ? -bus.rs : bus.rs;
    rt_mag = (sgn && bus.rt[31]) ? -bus.rt : bus.rt;

    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    div_shift = {rem_q, acc_q[31]};
    div_trial = div_shift - {1'b0, a_q};
    if (is_div_q) begin
      acc_d = {32'd0, acc_q[30:0], ~div_trial[32]};
      rem_d = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
      rem_d = rem_q;
    end

    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = neg_lo_q ? -acc_q[31:0] : acc_q[31:0];
    rem_fix  = neg_hi_q ? -rem_q : rem_q;
    if (dz_q)          result = {dvd_q, 32'hFFFF_FFFF};
    else if (is_div_q) result = {rem_fix, quo_fix};
    else               result = prod_fix;

`ifdef MULDIV_MULT_1CYC_EN
    prod_1c = bus.op[0] ? ({32'd0, bus.rs} * {32'd0, bus.rt})
                        : ({{32{bus.rs[31]}}, bus.rs} * {{32{bus.rt[31]}}, bus.rt});
`endif
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      acc_q    <= '0;
      hilo_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + {{(ITER_BITS-1){1'b0}}, 1'b1};
          if (cnt_q == '1) state_q <= S_FIX;
        end
        S_FIX: begin
          hilo_q   <= result;
          done_q   <= 1'b1;
          dz_out_q <= dz_q;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: ;
      endcase

      if (take) begin
        case (bus.op)
          OP_MTHI: begin
            hilo_q[63:32] <= bus.rs;
            done_q        <= 1'b1;
          end
          OP_MTLO: begin
            hilo_q[31:0] <= bus.rs;
            done_q       <= 1'b1;
          end
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            is_div_q <= bus.op[1];
            a_q      <= bus.op[1] ? rt_mag : rs_mag;
            acc_q    <= {32'd0, (bus.op[1] ? rs_mag : rt_mag)};
            rem_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= sgn && (bus.rs[31] ^ bus.rt[31]);
            neg_hi_q <= sgn && bus.rs[31];
            dz_q     <= bus.op[1] && (bus.rt == 32'd0);
            dvd_q    <= bus.rs;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
`ifdef MULDIV_MULT_1CYC_EN
            if (!bus.op[1]) begin
              acc_q    <= prod_1c;
              neg_lo_q <= 1'b0;
              state_q  <= S_FIX;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_out_q;
  assign bus.hilo_q      = hilo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;
  logic clk_cpu = 1'b0;
  logic reset   = 1'b0;
  muldiv_unit_if bus();

  muldiv_unit #(.ITER_BITS(5)) dut (.clk_cpu(clk_cpu), .reset(reset), .bus(bus));

  always #5 clk_cpu = ~clk_cpu;

`ifdef MULDIV_MULT_1CYC_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_hilo;

  // Reference: bit 64 is div_by_zero, bits 63:0 the new {HI, LO}
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] old);
    logic [63:0] r;
    logic        dz;
    longint      p;
    int          sa, sb;
    logic [31:0] q, rm;
    dz = 1'b0;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); r = p; end
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) begin r = {a, 32'hFFFF_FFFF}; dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin q = sa / sb; rm = sa % sb; r = {rm, q}; end
      end
      3'd3: begin
        if (b == 32'd0) begin r = {a, 32'hFFFF_FFFF}; dz = 1'b1; end
        else r = {a % b, a / b};
      end
      3'd4: r = {a, old[31:0]};
      3'd5: r = {old[63:32], a};
      default: r = old;
    endcase
    return {dz, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issues one request and waits (bounded) for done; leaves the bench on a negedge
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output bit timed_out, output logic [63:0] h,
                        output logic dz);
    int n;
    @(negedge clk_cpu);
    bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
    @(negedge clk_cpu);
    bus.start = 1'b0;
    bcyc = 0; n = 0;
    while (!bus.done && n < 200) begin
      if (bus.busy) bcyc++;
      n++;
      @(negedge clk_cpu);
    end
    timed_out = !bus.done;
    h  = bus.hilo_q;
    dz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 3'd0; bus.rs = '0; bus.rt = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk_cpu);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", bus.div_by_zero); end
    checks++; if (bus.hilo_q !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h want 0", bus.hilo_q); end
    reset = 1'b1;
    model_hilo = 64'd0;
    repeat (2) @(negedge clk_cpu);
  endtask

  task automatic test_directed();
    logic [2:0]  ops  [5] = '{3'd1, 3'd0, 3'd2, 3'd2, 3'd3};
    logic [31:0] as   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
    logic [31:0] bs   [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] exps [5] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                              64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                              64'h0000_0064_FFFF_FFFF};
    logic        edz  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int bcyc; bit to; logic [63:0] h; logic dz; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], bcyc, to, h, dz);
      lat = (ops[i] < 3'd2) ? MUL_LAT : DIV_LAT;
      checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout got no done want done", i); end
      checks++; if (h !== exps[i]) begin errors++; $display("FAIL dir%0d_hilo got %h want %h", i, h, exps[i]); end
      checks++; if (dz !== edz[i]) begin errors++; $display("FAIL dir%0d_dz got %b want %b", i, dz, edz[i]); end
      checks++; if (bcyc != lat) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcyc, lat); end
      model_hilo = exps[i];
    end
  endtask

  task automatic test_move();
    @(negedge clk_cpu);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs = 32'h1234_5678;
    @(negedge clk_cpu);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL mthi_flags got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy); end
    checks++; if (bus.hilo_q[63:32] !== 32'h1234_5678) begin errors++;
      $display("FAIL mthi_hi got %h want 12345678", bus.hilo_q[63:32]); end
    bus.op = 3'd5; bus.rs = 32'h9ABC_DEF0;
    @(negedge clk_cpu);
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL mtlo_flags got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy); end
    checks++; if (bus.hilo_q !== 64'h1234_5678_9ABC_DEF0) begin errors++;
      $display("FAIL move_hilo got %h want 123456789abcdef0", bus.hilo_q); end
    @(negedge clk_cpu);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL move_done_drop got %b want 0", bus.done); end
    model_hilo = 64'h1234_5678_9ABC_DEF0;
  endtask

  task automatic test_ignore_busy();
    int n;
    @(negedge clk_cpu);
    bus.start = 1'b1; bus.op = 3'd2; bus.rs = 32'd1000; bus.rt = 32'd7;
    @(negedge clk_cpu);
    bus.start = 1'b0;
    repeat (9) @(negedge clk_cpu);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs = 32'hDEAD_BEEF;
    @(negedge clk_cpu);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", bus.busy); end
    checks++; if (bus.hilo_q !== model_hilo) begin errors++;
      $display("FAIL ignore_hilo_hold got %h want %h", bus.hilo_q, model_hilo); end
    n = 0;
    while (!bus.done && n < 100) begin n++; @(negedge clk_cpu); end
    checks++; if (!bus.done) begin errors++; $display("FAIL ignore_timeout got no done want done"); end
    checks++; if (bus.hilo_q !== {32'd6, 32'd142}) begin errors++;
      $display("FAIL ignore_result got %h want %h", bus.hilo_q, {32'd6, 32'd142}); end
    model_hilo = {32'd6, 32'd142};
    @(negedge clk_cpu);
    checks++; if (bus.hilo_q !== model_hilo || bus.busy !== 1'b0) begin errors++;
      $display("FAIL ignore_not_queued got hilo=%h busy=%b want %h busy=0", bus.hilo_q, bus.busy, model_hilo); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk_cpu);
    bus.start = 1'b1; bus.op = 3'd3; bus.rs = 32'd1000; bus.rt = 32'd10;
    @(negedge clk_cpu);
    bus.start = 1'b0;
    repeat (32) @(negedge clk_cpu);
    bus.start = 1'b1; bus.op = 3'd0; bus.rs = 32'hFFFF_FFFE; bus.rt = 32'd3;
    @(negedge clk_cpu);
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", bus.done); end
    checks++; if (bus.hilo_q !== {32'd0, 32'd100}) begin errors++;
      $display("FAIL b2b_first_hilo got %h want %h", bus.hilo_q, {32'd0, 32'd100}); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy got %b want 1", bus.busy); end
    @(negedge clk_cpu);
    n = 0;
    while (!bus.done && n < 100) begin n++; @(negedge clk_cpu); end
    checks++; if (bus.hilo_q !== 64'hFFFF_FFFF_FFFF_FFFA || !bus.done) begin errors++;
      $display("FAIL b2b_second_hilo got %h done=%b want fffffffffffffffa done=1", bus.hilo_q, bus.done); end
    model_hilo = 64'hFFFF_FFFF_FFFF_FFFA;
  endtask

  task automatic test_reset_mid();
    int bcyc; bit to; logic [63:0] h; logic dz;
    @(negedge clk_cpu);
    bus.start = 1'b1; bus.op = 3'd3; bus.rs = $urandom; bus.rt = 32'd13;
    @(negedge clk_cpu);
    bus.start = 1'b0;
    repeat (9) @(negedge clk_cpu);
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
      $display("FAIL midreset_flags got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.hilo_q !== 64'd0) begin errors++; $display("FAIL midreset_hilo got %h want 0", bus.hilo_q); end
    @(negedge clk_cpu);
    reset = 1'b1;
    model_hilo = 64'd0;
    run_op(3'd1, 32'd3, 32'd5, bcyc, to, h, dz);
    checks++; if (to || h !== 64'd15) begin errors++;
      $display("FAIL postreset_multu got %h timeout=%b want 15", h, to); end
    checks++; if (bcyc != MUL_LAT) begin errors++;
      $display("FAIL postreset_busy_cycles got %0d want %0d", bcyc, MUL_LAT); end
    model_hilo = 64'd15;
  endtask

  task automatic test_random();
    int bcyc; bit to; logic [63:0] h; logic dz; logic [64:0] e;
    logic [2:0] op; logic [31:0] a, b; int lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      if (op >= 3'd6) begin
        @(negedge clk_cpu);
        bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
        @(negedge clk_cpu);
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hilo_q !== model_hilo) begin errors++;
          $display("FAIL rnd%0d_noop got done=%b busy=%b hilo=%h want 0 0 %h", i, bus.done, bus.busy, bus.hilo_q, model_hilo); end
      end else begin
        e = ref_op(op, a, b, model_hilo);
        run_op(op, a, b, bcyc, to, h, dz);
        lat = (op >= 3'd4) ? 0 : (op < 3'd2) ? MUL_LAT : DIV_LAT;
        checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout op=%0d got no done want done", i, op); end
        checks++; if (h !== e[63:0]) begin errors++;
          $display("FAIL rnd%0d_hilo op=%0d rs=%h rt=%h got %h want %h", i, op, a, b, h, e[63:0]); end
        checks++; if (dz !== e[64]) begin errors++; $display("FAIL rnd%0d_dz got %b want %b", i, dz, e[64]); end
        checks++; if (bcyc != lat) begin errors++; $display("FAIL rnd%0d_busy_cycles got %0d want %0d", i, bcyc, lat); end
        model_hilo = e[63:0];
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_move();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
